// File: rtl/memory_stage.sv
// MEM pipeline stage: drives a word-wide synchronous RAM for loads and stores, extends
// sub-word load data and builds sub-word stores by read-modify-write.
module memory_stage #(
   parameter int unsigned RAM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] result_alu,
   input  logic [31:0] rs2_value,
   input  logic [4:0]  in_RegDest,
   input  logic        in_RegWrite,
   output logic [31:0] ram_address,
   output logic [31:0] ram_data_in,
   output logic        ram_write_enable,
   input  logic [31:0] ram_data_out,
   output logic        busy,
   output logic        mem_done,
   output logic [31:0] data_mem,
   output logic [31:0] result_alu_out,
   output logic [4:0]  out_RegDest,
   output logic        out_RegWrite,
   output logic        mem_fault
);

   localparam int unsigned CntW = (RAM_LATENCY < 2) ? 1 : $clog2(RAM_LATENCY + 1);
   localparam logic [CntW-1:0] CntInit = CntW'(RAM_LATENCY);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   typedef enum logic [1:0] {StIdle, StRead, StRmwRead, StWrite} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [1:0]      lo_q, lo_d;
   logic [2:0]      f3_q, f3_d;
   logic [31:0]     alu_q, alu_d;
   logic [4:0]      rd_q, rd_d;
   logic            rw_q, rw_d;
   logic            done_q, done_d;
   logic            fault_q, fault_d;
   logic [31:0]     dmem_q, dmem_d;

   logic        mem_op, illegal, misaligned, fault;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_ext, mask, ins, merged;

   assign mem_op = MemRead | MemWrite;

   always_comb begin
      illegal    = (funct3[1:0] == 2'b11) || (funct3[2] && (MemWrite || funct3[1]))
                   || (MemRead && MemWrite);
      misaligned = ((funct3[1:0] == 2'b01) && result_alu[0])
                   || ((funct3[1:0] == 2'b10) && (result_alu[1:0] != 2'b00));
      fault      = mem_op && (illegal || misaligned);
   end

   always_comb begin
      lane_byte = ram_data_out[{lo_q, 3'b000} +: 8];
      lane_half = lo_q[1] ? ram_data_out[31:16] : ram_data_out[15:0];
      unique case (f3_q)
         3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
         3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
         3'b100:  load_ext = {24'h0, lane_byte};
         3'b101:  load_ext = {16'h0, lane_half};
         default: load_ext = ram_data_out;
      endcase
   end

   // Store data stays in wdata_q until the merge replaces it with the full word.
   always_comb begin
      if (f3_q[1:0] == 2'b00) begin
         mask = 32'h0000_00FF << {lo_q, 3'b000};
         ins  = {4{wdata_q[7:0]}};
      end else begin
         mask = lo_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
         ins  = {2{wdata_q[15:0]}};
      end
      merged = (ram_data_out & ~mask) | (ins & mask);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      lo_d    = lo_q;
      f3_d    = f3_q;
      alu_d   = alu_q;
      rd_d    = rd_q;
      rw_d    = rw_q;
      fault_d = fault_q;
      dmem_d  = dmem_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               addr_d  = {result_alu[31:2], 2'b00};
               wdata_d = rs2_value;
               lo_d    = result_alu[1:0];
               f3_d    = funct3;
               alu_d   = result_alu;
               rd_d    = in_RegDest;
               rw_d    = in_RegWrite & ~fault;
               fault_d = fault;
               dmem_d  = 32'h0;
               if (fault || !mem_op) begin
                  done_d = 1'b1;
               end else if (MemRead) begin
                  state_d = StRead;
                  cnt_d   = CntInit;
               end else if (funct3[1:0] == 2'b10) begin
                  state_d = StWrite;
               end else begin
                  state_d = StRmwRead;
                  cnt_d   = CntInit;
               end
            end
         end
         StRead: begin
            if (cnt_q == CntOne) begin
               dmem_d  = load_ext;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
         StRmwRead: begin
            if (cnt_q == CntOne) begin
               wdata_d = merged;
               cnt_d   = '0;
               state_d = StWrite;
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
         StWrite: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         lo_q    <= 2'b00;
         f3_q    <= 3'b000;
         alu_q   <= 32'h0;
         rd_q    <= 5'h0;
         rw_q    <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
         dmem_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         lo_q    <= lo_d;
         f3_q    <= f3_d;
         alu_q   <= alu_d;
         rd_q    <= rd_d;
         rw_q    <= rw_d;
         done_q  <= done_d;
         fault_q <= fault_d;
         dmem_q  <= dmem_d;
      end
   end

   assign ram_address      = addr_q;
   assign ram_data_in      = wdata_q;
   assign ram_write_enable = (state_q == StWrite);
   assign busy             = (state_q != StIdle);
   assign mem_done         = done_q;
   assign data_mem         = dmem_q;
   assign result_alu_out   = alu_q;
   assign out_RegDest      = rd_q;
   assign out_RegWrite     = rw_q;
   assign mem_fault        = fault_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: vector table plus scoreboard of expected writeback results,
// with hand sequences for back-to-back issue, ignored input while busy and mid-write reset.
module tb_memory_stage;

   typedef struct {
      string       name;
      bit          rd_op;
      bit          wr_op;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] rs2;
      logic [4:0]  rd;
      bit          rw;
      bit          pl;
      logic [31:0] pre;
      logic [31:0] x_data;
      bit          x_fault;
      bit          x_rw;
      int          lat;
      bit          ck_ram;
      logic [31:0] x_word;
      int          x_we;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] data;
      logic [31:0] alu;
      logic [4:0]  rd;
      bit          rw;
      bit          fault;
      int          cyc;
   } exp_t;

   logic        clk, rst, in_valid, mem_read, mem_write, in_reg_write;
   logic [2:0]  funct3;
   logic [31:0] result_alu, rs2_value, ram_address, ram_data_in, ram_data_out;
   logic [4:0]  in_reg_dest, out_reg_dest;
   logic        ram_write_enable, busy, mem_done, out_reg_write, mem_fault;
   logic [31:0] data_mem, result_alu_out;

   logic [31:0] mem [0:63];
   logic        pre_en;
   logic [5:0]  pre_idx;
   logic [31:0] pre_val;
   int          we_cnt = 0;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_miss = 0;
   exp_t        exp_q[$];
   exp_t        e_mon;
   vec_t        vecs[$];

   memory_stage #(.RAM_LATENCY(1)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .MemRead          (mem_read),
      .MemWrite         (mem_write),
      .funct3           (funct3),
      .result_alu       (result_alu),
      .rs2_value        (rs2_value),
      .in_RegDest       (in_reg_dest),
      .in_RegWrite      (in_reg_write),
      .ram_address      (ram_address),
      .ram_data_in      (ram_data_in),
      .ram_write_enable (ram_write_enable),
      .ram_data_out     (ram_data_out),
      .busy             (busy),
      .mem_done         (mem_done),
      .data_mem         (data_mem),
      .result_alu_out   (result_alu_out),
      .out_RegDest      (out_reg_dest),
      .out_RegWrite     (out_reg_write),
      .mem_fault        (mem_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM with one-edge latency: data for the registered address is ready by the next edge.
   assign ram_data_out = mem[ram_address[7:2]];

   always @(posedge clk) begin
      if (ram_write_enable) mem[ram_address[7:2]] <= ram_data_in;
      if (pre_en) mem[pre_idx] <= pre_val;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_write_enable) we_cnt <= we_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && mem_done) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_mem_done: got mem_done=1 at cycle %0d, expected 0", cyc);
         end else begin
            e_mon = exp_q.pop_front();
            chk({e_mon.name, "_done_cycle"}, cyc, e_mon.cyc);
            chk({e_mon.name, "_data_mem"}, data_mem, e_mon.data);
            chk({e_mon.name, "_alu_out"}, result_alu_out, e_mon.alu);
            chk({e_mon.name, "_rd"}, {27'h0, out_reg_dest}, {27'h0, e_mon.rd});
            chk({e_mon.name, "_regwrite"}, {31'h0, out_reg_write}, {31'h0, e_mon.rw});
            chk({e_mon.name, "_fault"}, {31'h0, mem_fault}, {31'h0, e_mon.fault});
         end
      end
   end

   function automatic vec_t mk(input string name, input bit rd_op, input bit wr_op,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] rs2, input logic [4:0] rd, input bit rw,
                               input bit pl, input logic [31:0] pre, input logic [31:0] x_data,
                               input bit x_fault, input bit x_rw, input int lat,
                               input bit ck_ram, input logic [31:0] x_word, input int x_we);
      vec_t v;
      v.name = name; v.rd_op = rd_op; v.wr_op = wr_op; v.f3 = f3; v.addr = addr;
      v.rs2 = rs2; v.rd = rd; v.rw = rw; v.pl = pl; v.pre = pre; v.x_data = x_data;
      v.x_fault = x_fault; v.x_rw = x_rw; v.lat = lat; v.ck_ram = ck_ram;
      v.x_word = x_word; v.x_we = x_we;
      return v;
   endfunction

   task automatic preload(input logic [31:0] addr, input logic [31:0] val);
      @(negedge clk);
      pre_en  = 1'b1;
      pre_idx = addr[7:2];
      pre_val = val;
      @(posedge clk);
      #1 pre_en = 1'b0;
   endtask

   // Drives one op for exactly one accept edge; optionally records its expected result.
   task automatic issue(input vec_t v, input bit push);
      exp_t e;
      @(negedge clk);
      in_valid     = 1'b1;
      mem_read     = v.rd_op;
      mem_write    = v.wr_op;
      funct3       = v.f3;
      result_alu   = v.addr;
      rs2_value    = v.rs2;
      in_reg_dest  = v.rd;
      in_reg_write = v.rw;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      if (push) begin
         e.name  = v.name;
         e.data  = v.x_data;
         e.alu   = v.addr;
         e.rd    = v.rd;
         e.rw    = v.x_rw;
         e.fault = v.x_fault;
         e.cyc   = cyc + v.lat;
         exp_q.push_back(e);
      end
      chk({v.name, "_busy"}, {31'h0, busy}, {31'h0, v.lat > 0});
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 20) begin
         n_vec++;
         n_miss++;
         $display("FAIL %s_drain: got %0d pending after 20 cycles, expected 0", name,
                  exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_we"}, {31'h0, ram_write_enable}, 32'h0);
      chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
      chk({tag, "_done"}, {31'h0, mem_done}, 32'h0);
      chk({tag, "_data_mem"}, data_mem, 32'h0);
      chk({tag, "_alu_out"}, result_alu_out, 32'h0);
      chk({tag, "_rd"}, {27'h0, out_reg_dest}, 32'h0);
      chk({tag, "_regwrite"}, {31'h0, out_reg_write}, 32'h0);
      chk({tag, "_fault"}, {31'h0, mem_fault}, 32'h0);
      chk({tag, "_ram_addr"}, ram_address, 32'h0);
      chk({tag, "_ram_din"}, ram_data_in, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      int   we0;
      rst = 1'b0; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
      result_alu = 32'h0; rs2_value = 32'h0; in_reg_dest = 5'h0; in_reg_write = 1'b0;
      pre_en = 1'b0; pre_idx = 6'h0; pre_val = 32'h0;

      //          name        rd wr f3      addr          rs2           rd rw pl pre
      //          x_data      flt xrw lat ck x_word  we
      vecs.push_back(mk("lw_10",   1,0,3'b010,32'h10,32'h0,5'd1,1,1,32'h80FF7F01,
                        32'h80FF7F01,0,1,1,1,32'h80FF7F01,0));
      vecs.push_back(mk("lb_13",   1,0,3'b000,32'h13,32'h0,5'd2,1,0,32'h0,
                        32'hFFFFFF80,0,1,1,1,32'h80FF7F01,0));
      vecs.push_back(mk("lbu_13",  1,0,3'b100,32'h13,32'h0,5'd3,1,0,32'h0,
                        32'h00000080,0,1,1,1,32'h80FF7F01,0));
      vecs.push_back(mk("lh_12",   1,0,3'b001,32'h12,32'h0,5'd4,1,0,32'h0,
                        32'hFFFF80FF,0,1,1,1,32'h80FF7F01,0));
      vecs.push_back(mk("lhu_10",  1,0,3'b101,32'h10,32'h0,5'd5,1,0,32'h0,
                        32'h00007F01,0,1,1,1,32'h80FF7F01,0));
      vecs.push_back(mk("lb_11",   1,0,3'b000,32'h11,32'h0,5'd6,1,0,32'h0,
                        32'h0000007F,0,1,1,1,32'h80FF7F01,0));
      vecs.push_back(mk("lb_12",   1,0,3'b000,32'h12,32'h0,5'd7,1,0,32'h0,
                        32'hFFFFFFFF,0,1,1,1,32'h80FF7F01,0));
      vecs.push_back(mk("sb_11",   0,1,3'b000,32'h11,32'h123456AA,5'd8,0,1,32'h11223344,
                        32'h0,0,0,2,1,32'h1122AA44,1));
      vecs.push_back(mk("sh_12",   0,1,3'b001,32'h12,32'h7777BEEF,5'd9,0,1,32'h11223344,
                        32'h0,0,0,2,1,32'hBEEF3344,1));
      vecs.push_back(mk("sb_13",   0,1,3'b000,32'h13,32'h0000005A,5'd10,0,1,32'h11223344,
                        32'h0,0,0,2,1,32'h5A223344,1));
      vecs.push_back(mk("sw_top",  0,1,3'b010,32'hFFFFFFFC,32'hDEADBEEF,5'd11,0,1,32'h0,
                        32'h0,0,0,1,1,32'hDEADBEEF,1));
      vecs.push_back(mk("lw_top",  1,0,3'b010,32'hFFFFFFFC,32'h0,5'd12,1,0,32'h0,
                        32'hDEADBEEF,0,1,1,1,32'hDEADBEEF,0));
      vecs.push_back(mk("lw_mis",  1,0,3'b010,32'h12,32'h0,5'd13,1,1,32'h80FF7F01,
                        32'h0,1,0,0,1,32'h80FF7F01,0));
      vecs.push_back(mk("sh_mis",  0,1,3'b001,32'h13,32'h0000FFFF,5'd14,1,1,32'h55667788,
                        32'h0,1,0,0,1,32'h55667788,0));
      vecs.push_back(mk("sbu_ill", 0,1,3'b100,32'h10,32'h000000FF,5'd15,1,0,32'h0,
                        32'h0,1,0,0,1,32'h55667788,0));
      vecs.push_back(mk("rdwr_ill",1,1,3'b010,32'h10,32'h0,5'd16,1,0,32'h0,
                        32'h0,1,0,0,1,32'h55667788,0));
      vecs.push_back(mk("f3_011",  1,0,3'b011,32'h10,32'h0,5'd17,1,0,32'h0,
                        32'h0,1,0,0,1,32'h55667788,0));
      vecs.push_back(mk("lh_odd",  1,0,3'b001,32'h11,32'h0,5'd18,1,0,32'h0,
                        32'h0,1,0,0,1,32'h55667788,0));
      vecs.push_back(mk("nonmem",  0,0,3'b000,32'h1234,32'h0,5'd5,1,0,32'h0,
                        32'h0,0,1,0,0,32'h0,0));
      vecs.push_back(mk("nonmem_f3",0,0,3'b111,32'h0000ABCD,32'h0,5'd7,1,0,32'h0,
                        32'h0,0,1,0,0,32'h0,0));

      #3;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) begin
         v = vecs[i];
         if (v.pl) preload(v.addr, v.pre);
         we0 = we_cnt;
         issue(v, 1'b1);
         wait_idle(v.name);
         chk({v.name, "_we_cycles"}, we_cnt - we0, v.x_we);
         if (v.ck_ram) chk({v.name, "_ram"}, mem[v.addr[7:2]], v.x_word);
      end

      // Non-memory op followed immediately by a load: no bubble between them.
      preload(32'h10, 32'h80FF7F01);
      issue(mk("b2b_alu", 0,0,3'b000,32'h1234,32'h0,5'd5,1,0,32'h0,
               32'h0,0,1,0,0,32'h0,0), 1'b1);
      issue(mk("b2b_lw", 1,0,3'b010,32'h10,32'h0,5'd6,1,0,32'h0,
               32'h80FF7F01,0,1,1,0,32'h0,0), 1'b1);
      wait_idle("b2b");

      // A request held through the busy window must be dropped, not queued.
      preload(32'h10, 32'h11223344);
      we0 = we_cnt;
      issue(mk("busy_sb", 0,1,3'b000,32'h11,32'h000000AA,5'd3,0,0,32'h0,
               32'h0,0,0,2,0,32'h0,0), 1'b1);
      @(negedge clk);
      in_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; result_alu = 32'h20;
      in_reg_dest = 5'd9; in_reg_write = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      in_valid = 1'b0; mem_read = 1'b0;
      wait_idle("busy_sb");
      repeat (3) @(negedge clk);
      #1;
      chk("busy_ignored_idle", {31'h0, busy}, 32'h0);
      chk("busy_sb_we_cycles", we_cnt - we0, 1);
      chk("busy_sb_ram", mem[4], 32'h1122AA44);

      // Reset asserted during the write cycle of a halfword store.
      preload(32'h20, 32'h11223344);
      we0 = we_cnt;
      issue(mk("rst_sh", 0,1,3'b001,32'h20,32'h0000BEEF,5'd4,0,0,32'h0,
               32'h0,0,0,2,0,32'h0,0), 1'b0);
      @(posedge clk);
      #2;
      chk("rst_sh_we_before", {31'h0, ram_write_enable}, 32'h1);
      rst = 1'b0;
      #1;
      chk_reset_outputs("mid_reset");
      @(posedge clk);
      #1;
      chk("rst_sh_ram", mem[8], 32'h11223344);
      chk("rst_sh_we_cycles", we_cnt - we0, 0);
      @(negedge clk);
      rst = 1'b1;
      issue(mk("post_rst_lw", 1,0,3'b010,32'h20,32'h0,5'd2,1,0,32'h0,
               32'h11223344,0,1,1,0,32'h0,0), 1'b1);
      wait_idle("post_rst_lw");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
